// File: rtl/raven_pe_pkg.sv
// Shared types and Q-format helpers for the PE drain path.
// Holds the gemm_uno mode encoding and the saturation bound functions that
// depend on the operand Q-format (INT_BW integer bits, FRA_BW fraction bits).
package raven_pe_pkg;

    typedef enum logic [1:0] {
        GEMM = 2'b00,
        DIV  = 2'b01,
        EXP  = 2'b10,
        LOG  = 2'b11
    } gemm_uno_e;

    // Largest accumulator value representable after the product shift.
    // A product of two Q(INT_BW,FRA_BW) operands carries 2*FRA_BW fraction bits.
    function automatic longint acc_hi(input int ib, input int fb);
        return (longint'(1) << (ib + 2 * fb)) - longint'(1);
    endfunction

    // Smallest accumulator value representable after the product shift.
    function automatic longint acc_lo(input int ib, input int fb);
        return -(longint'(1) << (ib + 2 * fb));
    endfunction

    // Positive clamp word: largest value of the (INT_BW+FRA_BW+1)-bit result.
    function automatic longint out_hi(input int ib, input int fb);
        return (longint'(1) << (ib + fb)) - longint'(1);
    endfunction

    // Negative clamp word: smallest value of the (INT_BW+FRA_BW+1)-bit result.
    function automatic longint out_lo(input int ib, input int fb);
        return -(longint'(1) << (ib + fb));
    endfunction

endpackage

// File: rtl/pe_drain_acc_sat.sv
// acc_sat: combinational accumulator-to-output conversion.
// GEMM mode drops FRA_BW fraction bits (truncation toward -inf) and clamps
// to the output Q-format; every other mode passes the low MUL_BW bits through.
// sat_o flags a GEMM sample that hit either clamp.
module acc_sat
    import raven_pe_pkg::*;
#(
    parameter int INT_BW = 5,
    parameter int FRA_BW = 7,
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32
) (
    input  logic [1:0]               mode_i,
    input  logic signed [ACC_BW-1:0] acc_i,
    output logic signed [MUL_BW-1:0] word_o,
    output logic                     sat_o
);

    localparam int TW = INT_BW + FRA_BW + 1;

    localparam logic signed [ACC_BW-1:0] ACC_HI = ACC_BW'(acc_hi(INT_BW, FRA_BW));
    localparam logic signed [ACC_BW-1:0] ACC_LO = ACC_BW'(acc_lo(INT_BW, FRA_BW));
    localparam logic signed [MUL_BW-1:0] WORD_HI = MUL_BW'(out_hi(INT_BW, FRA_BW));
    localparam logic signed [MUL_BW-1:0] WORD_LO = MUL_BW'(out_lo(INT_BW, FRA_BW));

    gemm_uno_e         mode;
    logic [TW-1:0]     slice;
    logic [MUL_BW-1:0] slice_ext;

    assign mode      = gemm_uno_e'(mode_i);
    assign slice     = acc_i[INT_BW+2*FRA_BW:FRA_BW];
    assign slice_ext = {{(MUL_BW-TW){slice[TW-1]}}, slice};

    // Select clamp, shifted slice or raw passthrough depending on mode.
    always_comb begin
        word_o = acc_i[MUL_BW-1:0];
        sat_o  = 1'b0;
        if (mode == GEMM) begin
            if (acc_i > ACC_HI) begin
                word_o = WORD_HI;
                sat_o  = 1'b1;
            end else if (acc_i < ACC_LO) begin
                word_o = WORD_LO;
                sat_o  = 1'b1;
            end else begin
                word_o = slice_ext;
            end
        end
    end

endmodule

// File: rtl/pe_drain.sv
// pe_drain: converts the bottom PE's accumulator output and queues it in a
// small FIFO for a valid/ready consumer. Words that arrive while full with
// no pop are dropped and flagged in the sticky ovf_o.
// Optional feature macro: PE_DRAIN_SATCNT_EN adds sat_cnt_o, a saturating
// count of pushed GEMM samples that were clamped.
module pe_drain
    import raven_pe_pkg::*;
#(
    parameter int INT_BW = 5,
    parameter int FRA_BW = 7,
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 gemm_uno,
    input  logic                       o_vld_i,
    input  logic signed [ACC_BW-1:0]   o_i,
    input  logic                       flush_i,
    output logic                       d_vld_o,
    input  logic                       d_rdy_i,
    output logic signed [MUL_BW-1:0]   d_o,
    output logic [$clog2(DEPTH):0]     cnt_o,
`ifdef PE_DRAIN_SATCNT_EN
    output logic [15:0]                sat_cnt_o,
`endif
    output logic                       ovf_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic signed [MUL_BW-1:0] sat_word;
    logic                     sat_flag;

    logic [MUL_BW-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              full;
    logic              push;
    logic              pop;

    acc_sat #(
        .INT_BW (INT_BW),
        .FRA_BW (FRA_BW),
        .MUL_BW (MUL_BW),
        .ACC_BW (ACC_BW)
    ) u_acc_sat (
        .mode_i (gemm_uno),
        .acc_i  (o_i),
        .word_o (sat_word),
        .sat_o  (sat_flag)
    );

    assign full = (cnt_q == CW'(DEPTH));
    assign pop  = (cnt_q != '0) && d_rdy_i;
    assign push = o_vld_i && (!full || pop);

    // Next-state for pointers, occupancy and overflow; flush wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CW'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CW'(1);
            end
            if (o_vld_i && !push) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage write; contents are not reset so the array can map to RAM.
    always_ff @(posedge clk) begin
        if (push && !flush_i && !rst) begin
            mem_q[wr_ptr_q] <= sat_word;
        end
    end

    assign d_vld_o = (cnt_q != '0);
    assign d_o     = d_vld_o ? mem_q[rd_ptr_q] : '0;
    assign cnt_o   = cnt_q;
    assign ovf_o   = ovf_q;

`ifdef PE_DRAIN_SATCNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;

    // Count accepted GEMM samples that clamped, holding at all-ones.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (flush_i) begin
            sat_cnt_d = '0;
        end else if (push && sat_flag && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    // Saturation counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_cnt_o = sat_cnt_q;
`else
    logic unused_sat;
    assign unused_sat = sat_flag;
`endif

endmodule

// File: doc/pe_drain.md
PE_DRAIN -- requirements
Module: pe_drain

Interface
REQ-001 SHALL have parameter INT_BW, default 5, integer bits of the PE operand Q-format.
REQ-002 SHALL have parameter FRA_BW, default 7, fraction bits of the PE operand Q-format.
REQ-003 SHALL have parameter MUL_BW, default 16, output data width.
REQ-004 SHALL have parameter ACC_BW, default 32, PE accumulator width.
REQ-005 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, >=2).
REQ-006 SHALL have port clk, input, 1, the single clock; all state on posedge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port gemm_uno, input, 2, 00 gemm, 01 div, 10 exp, 11 log; qualifies each sample.
REQ-009 SHALL have port o_vld_i, input, 1, the bottom PE's o_o is valid this cycle.
REQ-010 SHALL have port o_i, input, ACC_BW signed, the bottom PE's o_o.
REQ-011 SHALL have port flush_i, input, 1, synchronous clear of FIFO and flags.
REQ-012 SHALL have port d_vld_o, input/output: output, 1, FIFO head valid.
REQ-013 SHALL have port d_rdy_i, input, 1, consumer accepts head.
REQ-014 SHALL have port d_o, output, MUL_BW signed, FIFO head data.
REQ-015 SHALL have port cnt_o, output, $clog2(DEPTH)+1, FIFO occupancy.
REQ-016 SHALL have port ovf_o, output, 1, sticky drop flag.

Function
REQ-017 Conversion for gemm_uno==00: o_i is Q(.,2*FRA_BW); o_i > 2^(INT_BW+2*FRA_BW)-1 -> 0x0FFF; o_i < -2^(INT_BW+2*FRA_BW) -> 0xF000 (defaults); else o_i[INT_BW+2*FRA_BW:FRA_BW] sign-extended to MUL_BW; truncation toward -inf, no rounding.
REQ-018 Conversion for gemm_uno!=00: o_i[MUL_BW-1:0] passed unchanged.
REQ-019 Push: when o_vld_i and (not full or pop this cycle); converted word written at tail.
REQ-020 Pop: when d_vld_o and d_rdy_i; head advances.
REQ-021 Latency: pushed word visible on d_o/d_vld_o the cycle after push; no empty bypass.
REQ-022 d_vld_o = (cnt_o != 0); d_o holds head while d_vld_o and not popped.
REQ-023 Full and o_vld_i without pop: word dropped, ovf_o set next cycle, stays set until rst/flush_i.
REQ-024 Simultaneous push and pop: cnt_o unchanged; order preserved.
REQ-025 Pointers wrap modulo DEPTH; cnt_o ranges 0..DEPTH.
REQ-026 flush_i has priority over push/pop: next cycle cnt_o=0, ovf_o=0, that cycle's o_vld_i dropped without setting ovf_o.
REQ-027 d_rdy_i while empty has no effect.

Reset
REQ-028 rst SHALL force next-cycle cnt_o=0, d_vld_o=0, d_o=0, ovf_o=0, pointers 0; overrides flush_i and in-flight pushes; storage contents need not clear.

Configuration
REQ-029 With PE_DRAIN_SATCNT_EN defined: add output sat_cnt_o (16 b), increments per pushed gemm sample that saturated (either bound), saturates at 0xFFFF, cleared by rst/flush_i.
REQ-030 Without PE_DRAIN_SATCNT_EN: no sat_cnt_o port, no counter logic; all other behaviour identical.

Structure
REQ-031 Package raven_pe_pkg SHALL hold the gemm_uno mode typedef (GEMM, DIV, EXP, LOG) and Q-format saturation constant functions of INT_BW/FRA_BW.
REQ-032 Conversion SHALL be sub-module acc_sat (combinational, outputs word plus sat flag); FIFO inline.

Verification
REQ-033 Reset then push gemm o_i=0x00004000 -> next cycle d_vld_o=1, d_o=0x0080, cnt_o=1.
REQ-034 Push gemm 0x00080000 and 0xFFF7FFFF -> d_o 0x0FFF then 0xF000; with macro sat_cnt_o=2.
REQ-035 d_rdy_i=0, push 5 words at DEPTH=4 -> cnt_o=4, ovf_o=1, drained order = first 4 words.
REQ-036 Full FIFO, o_vld_i and d_rdy_i same cycle -> cnt_o stays 4, ovf_o stays 0, new word last out.
REQ-037 Push exp-mode o_i=0x12345678 -> d_o=0x5678, sat_cnt_o unchanged.
REQ-038 Three words queued, assert flush_i with o_vld_i -> next cycle cnt_o=0, d_vld_o=0, ovf_o=0; rst mid-stream same result.
